// File: rtl/relobi_ecc_fifo.sv
// relobi_ecc_fifo: FIFO for relOBI payloads storing each entry as a Hsiao SEC-DED codeword.
// Entries are encoded on push and decoded combinationally at the head. Single-bit upsets are
// corrected (EccMode 2) or only flagged (EccMode 1). Multi-bit upsets are flagged, and a
// saturating counter tracks popped entries that had errors.
module relobi_ecc_fifo #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 4,
  parameter int unsigned EccMode  = 2,
  parameter int unsigned CntWidth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [Width-1:0]           in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [Width-1:0]           out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output logic                       single_err_o,
  output logic                       multi_err_o,
  output logic [CntWidth-1:0]        err_cnt_o,
  input  logic                       err_cnt_clr_i
);

  // Smallest r for which there are at least k odd-weight (>=3) columns: 2^(r-1) - r >= k.
  function automatic int unsigned min_ecc(input int unsigned k);
    int unsigned r;
    r = 2;
    while (((32'd1 << (r - 1)) - r) < k) r++;
    return r;
  endfunction

  localparam int unsigned EccWidth = min_ecc(Width);
  localparam int unsigned StoreW   = (EccMode == 0) ? Width : Width + EccWidth;
  localparam int unsigned PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned UsageW   = $clog2(Depth + 1);

  typedef logic [Width-1:0][EccWidth-1:0] hcol_t;

  // Data-bit columns of H: distinct odd-weight vectors of weight >= 3, taken in ascending order.
  // Check bits own the weight-1 columns, so every single error has a unique odd syndrome.
  function automatic hcol_t gen_cols();
    hcol_t       c;
    int unsigned n;
    c = '0;
    n = 0;
    for (int unsigned v = 0; v < (32'd1 << EccWidth); v++) begin
      if ((n < Width) && (($countones(v) % 2) == 1) && ($countones(v) >= 3)) begin
        c[n] = v[EccWidth-1:0];
        n++;
      end
    end
    return c;
  endfunction

  localparam hcol_t HCols = gen_cols();

  function automatic logic [EccWidth-1:0] encode(input logic [Width-1:0] d);
    logic [EccWidth-1:0] e;
    e = '0;
    for (int i = 0; i < Width; i++) begin
      if (d[i]) e ^= HCols[i];
    end
    return e;
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  logic [StoreW-1:0]   mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [UsageW-1:0]   usage_q, usage_d;
  logic [CntWidth-1:0] err_cnt_q, err_cnt_d;

  logic                not_full, not_empty, push, pop;
  logic [StoreW-1:0]   wr_word, head_word;
  logic [Width-1:0]    head_data, fixed_data;
  logic                single_det, multi_det;

  assign not_full  = (usage_q != UsageW'(Depth));
  assign not_empty = (usage_q != '0);
  // A flush cycle neither stores a push nor reports a pop.
  assign push      = in_valid_i && not_full && !flush_i;
  assign pop       = not_empty && out_ready_i && !flush_i;

  assign head_word = mem_q[rd_ptr_q];
  assign head_data = head_word[Width-1:0];

  if (EccMode == 0) begin : g_no_ecc
    assign wr_word    = in_data_i;
    assign single_det = 1'b0;
    assign multi_det  = 1'b0;
    assign fixed_data = head_data;
  end else begin : g_ecc
    logic [EccWidth-1:0] head_ecc, syndrome;
    logic [Width-1:0]    flip;

    assign wr_word  = {encode(in_data_i), in_data_i};
    assign head_ecc = head_word[StoreW-1:Width];
    assign syndrome = head_ecc ^ encode(head_data);

    // Classify the head syndrome: a match on any H column is a single error, anything else nonzero is multi.
    always_comb begin
      single_det = 1'b0;
      flip       = '0;
      if ($countones(syndrome) == 1) begin
        single_det = 1'b1;
      end else begin
        for (int i = 0; i < Width; i++) begin
          if (syndrome == HCols[i]) begin
            single_det = 1'b1;
            flip[i]    = 1'b1;
          end
        end
      end
    end

    assign multi_det  = (syndrome != '0) && !single_det;
    assign fixed_data = (EccMode == 2) ? (head_data ^ flip) : head_data;
  end

  assign in_ready_o   = not_full;
  assign out_valid_o  = not_empty;
  assign usage_o      = usage_q;
  assign out_data_o   = not_empty ? fixed_data : '0;
  assign single_err_o = pop && single_det;
  assign multi_err_o  = pop && multi_det;
  assign err_cnt_o    = err_cnt_q;

  // Next-state for pointers, occupancy and the saturating error counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    usage_d   = usage_q;
    err_cnt_d = err_cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (push && !pop) usage_d = usage_q + UsageW'(1);
      else if (pop && !push) usage_d = usage_q - UsageW'(1);
    end
    if (err_cnt_clr_i) begin
      err_cnt_d = '0;
    end else if ((single_err_o || multi_err_o) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CntWidth'(1);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usage_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usage_q   <= usage_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Codeword storage; left unreset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_word;
  end

endmodule
